// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared kind codes, opcode/funct encodings, FSM states and word packers
package instr_encoder_pkg;
  localparam logic [4:0] K_ADD  = 5'd0;
  localparam logic [4:0] K_SUB  = 5'd1;
  localparam logic [4:0] K_AND  = 5'd2;
  localparam logic [4:0] K_OR   = 5'd3;
  localparam logic [4:0] K_XOR  = 5'd4;
  localparam logic [4:0] K_SLL  = 5'd5;
  localparam logic [4:0] K_SRL  = 5'd6;
  localparam logic [4:0] K_SRA  = 5'd7;
  localparam logic [4:0] K_JR   = 5'd8;
  localparam logic [4:0] K_ADDI = 5'd9;
  localparam logic [4:0] K_ANDI = 5'd10;
  localparam logic [4:0] K_ORI  = 5'd11;
  localparam logic [4:0] K_XORI = 5'd12;
  localparam logic [4:0] K_LW   = 5'd13;
  localparam logic [4:0] K_SW   = 5'd14;
  localparam logic [4:0] K_BEQ  = 5'd15;
  localparam logic [4:0] K_BNE  = 5'd16;
  localparam logic [4:0] K_LUI  = 5'd17;
  localparam logic [4:0] K_J    = 5'd18;
  localparam logic [4:0] K_JAL  = 5'd19;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational packing of one symbolic instruction into a MIPS word
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);
  // kind decode; unused fields are zeroed so the word matches what the control unit decodes
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      K_ADD:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, F_ADD);
      K_SUB:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, F_SUB);
      K_AND:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, F_AND);
      K_OR:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, F_OR);
      K_XOR:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, F_XOR);
      K_SLL:   o_word = pack_r(5'd0, i_rt, i_rd, i_shamt, F_SLL);
      K_SRL:   o_word = pack_r(5'd0, i_rt, i_rd, i_shamt, F_SRL);
      K_SRA:   o_word = pack_r(5'd0, i_rt, i_rd, i_shamt, F_SRA);
      K_JR:    o_word = pack_r(i_rs, 5'd0, 5'd0, 5'd0, F_JR);
      K_ADDI:  o_word = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
      K_ANDI:  o_word = pack_i(OP_ANDI, i_rs, i_rt, i_imm);
      K_ORI:   o_word = pack_i(OP_ORI, i_rs, i_rt, i_imm);
      K_XORI:  o_word = pack_i(OP_XORI, i_rs, i_rt, i_imm);
      K_LW:    o_word = pack_i(OP_LW, i_rs, i_rt, i_imm);
      K_SW:    o_word = pack_i(OP_SW, i_rs, i_rt, i_imm);
      K_BEQ:   o_word = pack_i(OP_BEQ, i_rs, i_rt, i_imm);
      K_BNE:   o_word = pack_i(OP_BNE, i_rs, i_rt, i_imm);
      K_LUI:   o_word = pack_i(OP_LUI, 5'd0, i_rt, i_imm);
      K_J:     o_word = pack_j(OP_J, i_target);
      K_JAL:   o_word = pack_j(OP_JAL, i_target);
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic instructions into consecutive instruction-memory words
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [4:0]        i_kind,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [31:0]         w_word;
  logic                w_illegal;

  instr_pack u_pack (
    .i_kind    (i_kind),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .i_rd      (i_rd),
    .i_shamt   (i_shamt),
    .i_imm     (i_imm),
    .i_target  (i_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // load FSM with registered write port; the address counter wraps at the memory size
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_addr <= i_base;
          r_cnt  <= i_len;
          r_err  <= 1'b0;
          r_busy <= 1'b1;
          if (i_len == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= LOAD;
            r_ready <= 1'b1;
          end
        end
        LOAD: if (i_in_valid) begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= w_word;
          r_addr  <= r_addr + ADDR_W'(1);
          r_cnt   <= r_cnt - LEN_W'(1);
          if (w_illegal) r_err <= 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            r_state <= FLUSH;
            r_ready <= 1'b0;
          end
        end
        FLUSH: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready   = r_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_waddr;
  assign o_imem_wdata = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed load scenarios checked against an arithmetic encoding model and scoreboard
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_base = '0;
  logic [6:0]  i_len = '0;
  logic        i_in_valid = 1'b0;
  logic [4:0]  i_kind = '0, i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
  logic [15:0] i_imm = '0;
  logic [25:0] i_target = '0;
  logic        o_in_ready, o_imem_we, o_busy, o_done, o_err;
  logic [5:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;

  int n_chk = 0;
  int n_fail = 0;
  logic [37:0] q[$];
  logic [5:0]  m_addr = '0;
  int          m_len = 0;
  logic        m_err = 1'b0;
  logic        prev_we = 1'b0;
  int funct_tab[9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
  int op_tab[11]   = '{8, 12, 13, 14, 35, 43, 4, 5, 15, 2, 3};

  instr_encoder dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_base       (i_base),
    .i_len        (i_len),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_kind       (i_kind),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .i_rd         (i_rd),
    .i_shamt      (i_shamt),
    .i_imm        (i_imm),
    .i_target     (i_target),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_encode(input int k, input int rs, input int rt, input int rd,
                                               input int sh, input int imm, input int tg);
    longint w;
    if (k > 19) return 32'h0;
    if (k < 9) begin
      if (k < 5) sh = 0;
      if (k >= 5 && k <= 7) rs = 0;
      if (k == 8) begin rt = 0; rd = 0; sh = 0; end
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sh) * 64 + funct_tab[k];
      return 32'(w);
    end
    if (k >= 18) return 32'(longint'(op_tab[k-9]) * 67108864 + tg);
    if (k == 17) rs = 0;
    w = longint'(op_tab[k-9]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
    return 32'(w);
  endfunction

  always @(negedge clk) begin
    logic [37:0] e;
    if (o_imem_we) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t", o_imem_addr, o_imem_wdata, $time);
      end else begin
        e = q.pop_front();
        chk("imem_addr", 32'(o_imem_addr), 32'(e[37:32]));
        chk("imem_wdata", o_imem_wdata, e[31:0]);
      end
    end
    if (o_done) begin
      chk("done_follows_last_write", 32'(prev_we), 32'(m_len != 0));
      chk("done_no_pending_writes", 32'(q.size()), 0);
      chk("err_at_done", 32'(o_err), 32'(m_err));
    end
    prev_we = o_imem_we;
  end

  task automatic do_start(input int b, input int l);
    i_start = 1'b1;
    i_base = 6'(b);
    i_len = 7'(l);
    m_addr = 6'(b);
    m_len = l;
    m_err = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 1);
    chk("ready_after_start", 32'(o_in_ready), 32'(l != 0));
    chk("err_cleared_by_start", 32'(o_err), 0);
  endtask

  task automatic send(input int k, input int rs, input int rt, input int rd, input int sh, input int imm,
                      input int tg, input bit has_lit, input logic [31:0] lit, input string nm);
    int n = 0;
    logic [31:0] w;
    w = model_encode(k, rs, rt, rd, sh, imm, tg);
    if (has_lit) chk(nm, w, lit);
    i_in_valid = 1'b1;
    i_kind = 5'(k); i_rs = 5'(rs); i_rt = 5'(rt); i_rd = 5'(rd); i_shamt = 5'(sh);
    i_imm = 16'(imm); i_target = 26'(tg);
    while (!o_in_ready && n < 20) begin @(negedge clk); n++; end
    if (!o_in_ready) chk("accept_timeout", 32'(o_in_ready), 1);
    else begin
      q.push_back({m_addr, w});
      m_addr = m_addr + 6'd1;
      if (k > 19) m_err = 1'b1;
    end
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 40) begin @(negedge clk); n++; end
    chk("done_seen", 32'(o_done), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 0);
    chk("busy_after_done", 32'(o_busy), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_we"}, 32'(o_imem_we), 0);
    chk({nm, "_addr"}, 32'(o_imem_addr), 0);
    chk({nm, "_wdata"}, o_imem_wdata, 0);
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_done"}, 32'(o_done), 0);
    chk({nm, "_err"}, 32'(o_err), 0);
    chk({nm, "_ready"}, 32'(o_in_ready), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    i_reset = 1'b0;
    @(negedge clk);

    do_start(0, 2);
    send(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820, "lit_add");
    send(9, 0, 1, 0, 0, 5, 0, 1, 32'h20010005, "lit_addi");
    wait_done();

    do_start(10, 6);
    send(13, 1, 2, 0, 0, 4, 0, 1, 32'h8C220004, "lit_lw");
    i_start = 1'b1; i_base = 6'd20; i_len = 7'd1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_while_busy_busy", 32'(o_busy), 1);
    chk("start_while_busy_ready", 32'(o_in_ready), 1);
    send(5, 7, 2, 4, 3, 0, 0, 1, 32'h000220C0, "lit_sll");
    send(15, 1, 2, 0, 0, 16'hFFFF, 0, 1, 32'h1022FFFF, "lit_beq");
    send(18, 0, 0, 0, 0, 0, 32'h10, 1, 32'h08000010, "lit_j");
    send(19, 0, 0, 0, 0, 0, 32'h100, 1, 32'h0C000100, "lit_jal");
    send(8, 31, 0, 5, 2, 0, 0, 1, 32'h03E00008, "lit_jr");
    wait_done();

    do_start(30, 3);
    send(0, 4, 5, 6, 7, 0, 0, 0, 32'h0, "");
    repeat (2) @(negedge clk);
    send(25, 1, 2, 3, 4, 5, 6, 1, 32'h00000000, "lit_illegal");
    chk("err_set_on_illegal", 32'(o_err), 1);
    repeat (2) @(negedge clk);
    chk("err_sticky_in_gap", 32'(o_err), 1);
    send(11, 3, 4, 0, 0, 16'h1234, 0, 1, 32'h34641234, "lit_ori");
    wait_done();
    chk("err_held_after_done", 32'(o_err), 1);

    do_start(62, 3);
    send(17, 9, 8, 0, 0, 16'hABCD, 0, 1, 32'h3C08ABCD, "lit_lui");
    send(14, 29, 31, 0, 0, 8, 0, 0, 32'h0, "");
    send(1, 2, 3, 4, 5, 0, 0, 0, 32'h0, "");
    wait_done();

    do_start(7, 0);
    wait_done();

    do_start(40, 4);
    i_in_valid = 1'b1;
    i_kind = 5'd2; i_rs = 5'd1; i_rt = 5'd1; i_rd = 5'd1; i_shamt = 5'd0;
    q.push_back({m_addr, model_encode(2, 1, 1, 1, 0, 0, 0)});
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b0;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    chk("mid_reset_no_late_write", 32'(o_imem_we), 0);
    i_reset = 1'b0;
    @(negedge clk);

    do_start(5, 1);
    send(4, 1, 2, 3, 9, 0, 0, 1, 32'h00221826, "lit_xor");
    wait_done();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
